// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter
// Round-robin arbiter sharing one system-bus slave port between N masters.
// Each master strobe is latched into a per-master pending slot. One
// transaction at a time is forwarded to the slave. The completion (ack, err,
// rdata) is returned to the owning master. A transaction that the slave does
// not acknowledge within TO wait cycles ends with an error completion.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   m_wen, m_ren        per-master single-cycle write/read strobes
//   m_addr, m_wdata     per-master address/write data, master i at [i*W +: W]
//   m_ack, m_err        per-master completion pulse and error flag
//   m_rdata             shared read data, held until the next completion
//   ovf                 sticky per-master "strobe dropped while pending"
//   s_wen, s_ren        slave strobes (one cycle)
//   s_addr, s_wdata     slave address/data, held until the next grant
//   s_rdata, s_ack, s_err  slave response
module sys_bus_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned TO = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    m_wen,
    input  logic [N-1:0]    m_ren,
    input  logic [N*AW-1:0] m_addr,
    input  logic [N*DW-1:0] m_wdata,
    output logic [N-1:0]    m_ack,
    output logic [N-1:0]    m_err,
    output logic [DW-1:0]   m_rdata,
    output logic [N-1:0]    ovf,
    output logic            s_wen,
    output logic            s_ren,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_ack,
    input  logic            s_err
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = $clog2(TO + 1);

    typedef enum logic {StIdle, StWait} state_e;
    state_e state_q, state_d;

    // Pending slots, one per master
    logic [N-1:0]         pend_q, pend_d;
    logic [N-1:0]         wr_q, wr_d;
    logic [N-1:0][AW-1:0] addr_q, addr_d;
    logic [N-1:0][DW-1:0] wdata_q, wdata_d;
    logic [N-1:0]         ovf_q, ovf_d;

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          s_wen_q, s_wen_d, s_ren_q, s_ren_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic [N-1:0]  m_ack_q, m_ack_d, m_err_q, m_err_d;
    logic [DW-1:0] m_rdata_q, m_rdata_d;

    logic          any_pend;
    logic [IW-1:0] sel, cand;
    logic          done;

    // Completion edge: slave ack wins over a simultaneous timeout
    assign done = (state_q == StWait) && (s_ack || (timer_q == TW'(TO)));

    // First pending master at or above rr_ptr, wrapping at N
    always_comb begin
        any_pend = 1'b0;
        sel      = rr_ptr_q;
        cand     = rr_ptr_q;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(rr_ptr_q) + k) % N);
            if (!any_pend && pend_q[cand]) begin
                any_pend = 1'b1;
                sel      = cand;
            end
        end
    end

    // Slot capture; a strobe on the owner's completion edge reloads the slot
    always_comb begin
        pend_d  = pend_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (done && (gnt_q == IW'(i))) begin
                pend_d[i] = 1'b0;
            end
            if (m_wen[i] || m_ren[i]) begin
                if (!pend_q[i] || (done && (gnt_q == IW'(i)))) begin
                    pend_d[i]  = 1'b1;
                    wr_d[i]    = m_wen[i];  // write wins over a same-cycle read
                    addr_d[i]  = m_addr[i*AW +: AW];
                    wdata_d[i] = m_wdata[i*DW +: DW];
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (any_pend) state_d = StWait;
            StWait:  if (done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs (registered below)
    always_comb begin
        s_wen_d   = 1'b0;
        s_ren_d   = 1'b0;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_ack_d   = '0;
        m_err_d   = '0;
        m_rdata_d = m_rdata_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        timer_d   = timer_q;
        case (state_q)
            StIdle: begin
                if (any_pend) begin
                    gnt_d     = sel;
                    s_wen_d   = wr_q[sel];
                    s_ren_d   = !wr_q[sel];
                    s_addr_d  = addr_q[sel];
                    s_wdata_d = wdata_q[sel];
                    timer_d   = '0;
                end
            end
            StWait: begin
                if (done) begin
                    m_ack_d[gnt_q] = 1'b1;
                    m_err_d[gnt_q] = s_ack ? s_err : 1'b1;
                    m_rdata_d      = (s_ack && !wr_q[gnt_q]) ? s_rdata : '0;
                    rr_ptr_d       = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + IW'(1);
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= '0;
            wr_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ovf_q     <= '0;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            timer_q   <= '0;
            s_wen_q   <= 1'b0;
            s_ren_q   <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_ack_q   <= '0;
            m_err_q   <= '0;
            m_rdata_q <= '0;
        end else begin
            pend_q    <= pend_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ovf_q     <= ovf_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            timer_q   <= timer_d;
            s_wen_q   <= s_wen_d;
            s_ren_q   <= s_ren_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_ack_q   <= m_ack_d;
            m_err_q   <= m_err_d;
            m_rdata_q <= m_rdata_d;
        end
    end

    assign m_ack   = m_ack_q;
    assign m_err   = m_err_q;
    assign m_rdata = m_rdata_q;
    assign ovf     = ovf_q;
    assign s_wen   = s_wen_q;
    assign s_ren   = s_ren_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter
// Directed scenarios followed by random traffic. A transaction-level model
// (pending set, round-robin pointer, one outstanding transfer) predicts every
// DUT output cycle by cycle.
module tb_sys_bus_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_wen = '0, m_ren = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N-1:0]    m_ack, m_err, ovf;
    logic [DW-1:0]   m_rdata;
    logic            s_wen, s_ren;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [DW-1:0]   s_rdata = '0;
    logic            s_ack = 1'b0, s_err = 1'b0;

    sys_bus_arbiter #(.N(N), .DW(DW), .AW(AW), .TO(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_wen   (m_wen),
        .m_ren   (m_ren),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .ovf     (ovf),
        .s_wen   (s_wen),
        .s_ren   (s_ren),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ack   (s_ack),
        .s_err   (s_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model
    int            cyc = 0;
    logic [N-1:0]  mp = '0, mwr = '0;
    logic [AW-1:0] maddr [N];
    logic [DW-1:0] mwd [N];
    int            rr = 0, g = 0, scyc = 0, free_cyc = 0, lat = 1;
    bit            busy = 0, twr = 0;
    // Expected outputs for the current cycle
    logic          e_sw = 0, e_sr = 0;
    logic [AW-1:0] e_saddr = '0;
    logic [DW-1:0] e_swd = '0, e_rdata = '0;
    logic [N-1:0]  e_ack = '0, e_err = '0, e_ovf = '0;

    // Stimulus values and observed slave addresses
    logic [AW-1:0] ma [N];
    logic [DW-1:0] mw [N];
    logic [AW-1:0] sq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the current cycle, advance the model, drive inputs, step one clock
    task automatic tick(input logic [N-1:0] wen, input logic [N-1:0] ren,
                        input logic ack, input logic err, input logic [DW-1:0] rd);
        logic [N-1:0] np;
        bit dn, found;
        int dg, idx;
        chk("s_wen", 64'(s_wen), 64'(e_sw));
        chk("s_ren", 64'(s_ren), 64'(e_sr));
        chk("s_addr", 64'(s_addr), 64'(e_saddr));
        chk("s_wdata", 64'(s_wdata), 64'(e_swd));
        chk("m_ack", 64'(m_ack), 64'(e_ack));
        chk("m_err", 64'(m_err), 64'(e_err));
        chk("m_rdata", 64'(m_rdata), 64'(e_rdata));
        chk("ovf", 64'(ovf), 64'(e_ovf));
        if (s_wen || s_ren) sq.push_back(s_addr);
        e_sw = 0; e_sr = 0; e_ack = '0; e_err = '0;
        dn = 0; dg = 0;
        if (busy && cyc >= scyc && (ack || (cyc - scyc == TO))) begin
            dn = 1; dg = g;
            e_ack[g] = 1'b1;
            e_err[g] = ack ? err : 1'b1;
            e_rdata  = (ack && !twr) ? rd : '0;
            busy = 0; free_cyc = cyc + 1; rr = (g + 1) % N;
        end
        if (!busy && cyc >= free_cyc && mp != '0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (!found && mp[idx]) begin found = 1; g = idx; end
            end
            busy = 1; scyc = cyc + 1; twr = mwr[g];
            e_sw = mwr[g]; e_sr = !mwr[g]; e_saddr = maddr[g]; e_swd = mwd[g];
            lat = ($urandom_range(0, 7) == 0) ? TO + 5 : int'($urandom_range(0, 4));
        end
        np = mp;
        if (dn) np[dg] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (wen[i] || ren[i]) begin
                if (mp[i] && !(dn && dg == i)) begin
                    e_ovf[i] = 1'b1;
                end else begin
                    np[i] = 1'b1; mwr[i] = wen[i]; maddr[i] = ma[i]; mwd[i] = mw[i];
                end
            end
        end
        mp = np;
        m_wen = wen; m_ren = ren;
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]  = ma[i];
            m_wdata[i*DW +: DW] = mw[i];
        end
        s_ack = ack; s_err = err; s_rdata = rd;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Idle cycles with a slave that acks one cycle after its strobe
    task automatic tick_auto(input int n);
        for (int j = 0; j < n; j++) begin
            tick('0, '0, busy && (cyc == scyc + 1), 1'b0, $urandom);
        end
    endtask

    task automatic do_reset();
        m_wen = '0; m_ren = '0; s_ack = 1'b0; s_err = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst s_wen", 64'(s_wen), 64'd0);
        chk("rst s_ren", 64'(s_ren), 64'd0);
        chk("rst s_addr", 64'(s_addr), 64'd0);
        chk("rst s_wdata", 64'(s_wdata), 64'd0);
        chk("rst m_ack", 64'(m_ack), 64'd0);
        chk("rst m_err", 64'(m_err), 64'd0);
        chk("rst m_rdata", 64'(m_rdata), 64'd0);
        chk("rst ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        mp = '0; e_ovf = '0; e_ack = '0; e_err = '0; e_sw = 0; e_sr = 0;
        e_saddr = '0; e_swd = '0; e_rdata = '0;
        busy = 0; rr = 0; free_cyc = cyc;
    endtask

    initial begin
        logic [N-1:0] w, r;
        logic a;
        for (int i = 0; i < N; i++) begin
            ma[i] = '0; mw[i] = '0; maddr[i] = '0; mwd[i] = '0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // Single read from master 1, slave acks one cycle after s_ren
        ma[1] = 32'h0000_1004;
        tick(3'b000, 3'b010, 0, 0, 0);
        tick_auto(1);
        chk("t1 s_ren", 64'(s_ren), 64'd1);
        chk("t1 s_addr", 64'(s_addr), 64'h1004);
        tick('0, '0, 0, 0, 0);
        tick('0, '0, 1, 0, 32'hDEAD_BEEF);
        chk("t1 m_ack", 64'(m_ack), 64'b010);
        chk("t1 m_err", 64'(m_err), 64'd0);
        chk("t1 m_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
        tick_auto(3);

        // Timeout: master 2 read (first from rr=2) then master 1 write
        ma[1] = 32'h310; ma[2] = 32'h320;
        tick(3'b010, 3'b100, 0, 0, 0);
        for (int j = 0; j < 33; j++) tick('0, '0, 0, 0, 0);
        chk("t3 no early ack", 64'(m_ack), 64'd0);
        tick('0, '0, 0, 0, 0);
        chk("t3 m_ack", 64'(m_ack), 64'b100);
        chk("t3 m_err", 64'(m_err), 64'b100);
        chk("t3 m_rdata", 64'(m_rdata), 64'd0);
        tick('0, '0, 0, 0, 0);
        chk("t3 next s_wen", 64'(s_wen), 64'd1);
        chk("t3 next s_addr", 64'(s_addr), 64'h310);
        tick_auto(4);

        // Simultaneous writes from masters 0 and 1, four rounds
        for (int rd = 0; rd < 4; rd++) begin
            ma[0] = 32'h100 + rd; ma[1] = 32'h200 + rd;
            mw[0] = 32'h11; mw[1] = 32'h22;
            sq.delete();
            tick(3'b011, 3'b000, 0, 0, 0);
            tick_auto(10);
            chk("t2 grants", 64'(sq.size()), 64'd2);
            chk("t2 first", 64'(sq[0]), 64'(32'h100 + rd));
            chk("t2 second", 64'(sq[1]), 64'(32'h200 + rd));
        end

        // Overflow on master 0, then capture on its completion edge
        ma[0] = 32'h400;
        tick(3'b001, 3'b000, 0, 0, 0);
        ma[0] = 32'h4FF;
        tick(3'b001, 3'b000, 0, 0, 0);
        chk("t4 ovf", 64'(ovf), 64'b001);
        chk("t4 s_wen", 64'(s_wen), 64'd1);
        chk("t4 s_addr", 64'(s_addr), 64'h400);
        tick('0, '0, 0, 0, 0);
        ma[0] = 32'h440;
        tick(3'b001, 3'b000, 1, 0, 0);
        chk("t4 m_ack", 64'(m_ack), 64'b001);
        tick('0, '0, 0, 0, 0);
        chk("t4 recapture s_wen", 64'(s_wen), 64'd1);
        chk("t4 recapture s_addr", 64'(s_addr), 64'h440);
        chk("t4 ovf unchanged", 64'(ovf), 64'b001);
        tick_auto(4);

        // Write and read on master 0 in the same cycle
        ma[0] = 32'h500;
        tick(3'b001, 3'b001, 0, 0, 0);
        tick_auto(1);
        chk("t5 s_wen", 64'(s_wen), 64'd1);
        chk("t5 s_ren", 64'(s_ren), 64'd0);
        tick_auto(4);

        // Reset during WAIT, then rr_ptr restarts at 0
        ma[1] = 32'h600;
        tick(3'b000, 3'b010, 0, 0, 0);
        tick_auto(5);
        ma[1] = 32'h610;
        tick(3'b000, 3'b010, 0, 0, 0);
        tick('0, '0, 0, 0, 0);
        chk("t6 in wait", 64'(s_ren), 64'd1);
        do_reset();
        ma[1] = 32'h620; ma[2] = 32'h720;
        tick(3'b000, 3'b110, 0, 0, 0);
        tick('0, '0, 0, 0, 0);
        chk("t6 post s_ren", 64'(s_ren), 64'd1);
        chk("t6 post s_addr", 64'(s_addr), 64'h620);
        tick_auto(12);

        // Random traffic with a mid-run reset
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            for (int i = 0; i < N; i++) begin
                ma[i] = $urandom; mw[i] = $urandom;
                w[i] = 1'b0; r[i] = 1'b0;
                case ($urandom_range(0, 39))
                    0: w[i] = 1'b1;
                    1: r[i] = 1'b1;
                    2: begin w[i] = 1'b1; r[i] = 1'b1; end
                    default: ;
                endcase
            end
            if (busy && cyc >= scyc) a = (cyc - scyc == lat);
            else a = ($urandom_range(0, 3) == 0);
            tick(w, r, a, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
